// File: rtl/rr_arbiter_n.sv
// ----------------------------------------------------------------------------
// rr_arbiter_n
//
// Round-robin arbiter for N requestors sharing one resource. The grant is
// registered (one cycle from req to grant, no combinational req->grant path).
// A rotating priority pointer moves to one past the last newly granted index,
// so every continuous requestor is served within N-1 cycles.
//
// Optional feature, compiled in when the macro RR_ARB_HOLD_EN is defined:
//   a 'hold' input lets the current grantee keep its grant for consecutive
//   cycles. While anyone else is requesting, one grantee keeps the grant for
//   at most MAX_HOLD cycles. A sole requestor may hold indefinitely.
//
// Parameters:
//   N         number of requestors (>= 2)
//   MAX_HOLD  max consecutive held cycles under contention (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req[N]       request vector
//   hold         grantee asks to keep its grant (RR_ARB_HOLD_EN only)
//   grant[N]     registered one-hot grant, or zero
//   grant_id     index of the grantee, valid with grant_valid
//   grant_valid  a grant is active
// ----------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
`ifdef RR_ARB_HOLD_EN
    input  logic          hold,
`endif
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          grant_valid
);

    if (N < 2 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_arbiter_n: requires N >= 2 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] ptr_q, ptr_d;

`ifdef RR_ARB_HOLD_EN
    // Counter width must be at least one bit even when MAX_HOLD == 1.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          others_req;
`endif

    logic          keep;
    logic          m_found;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] u_idx;
    logic [IW-1:0] win_idx;

    // ------------------------------------------------------------------
    // Winner search: lowest set bit at or above ptr, else lowest set bit
    // overall. Scanning downward lets the last hit be the lowest index.
    // ------------------------------------------------------------------
    always_comb begin
        m_found = 1'b0;
        m_idx   = '0;
        u_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                u_idx = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    m_found = 1'b1;
                    m_idx   = IW'(i);
                end
            end
        end
        win_idx = m_found ? m_idx : u_idx;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
`ifdef RR_ARB_HOLD_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
`ifdef RR_ARB_HOLD_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
`ifdef RR_ARB_HOLD_EN
        // Once the counter is saturated the grantee may only continue if
        // nobody else is waiting.
        others_req = |(req & ~grant_q);
        keep = (state_q == S_GRANT) && hold && req[grant_id_q] &&
               ((hold_cnt_q < HOLD_LAST) || !others_req);
        hold_cnt_d = '0;
`else
        keep = 1'b0;
`endif
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;

        if (keep) begin
            // Held grant: pointer stays where it was set at grant issue.
`ifdef RR_ARB_HOLD_EN
            hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                                   : hold_cnt_q + 1'b1;
`endif
        end else if (|req) begin
            state_d           = S_GRANT;
            grant_d           = '0;
            grant_d[win_idx]  = 1'b1;
            grant_id_d        = win_idx;
            ptr_d             = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
        end else begin
            state_d    = S_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from registers
    // ------------------------------------------------------------------
    always_comb begin
        grant       = grant_q;
        grant_id    = grant_id_q;
        grant_valid = (state_q == S_GRANT);
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
`ifdef RR_ARB_HOLD_EN
    logic       hold;
`endif

    int checks = 0;
    int errors = 0;

    rr_arbiter_n #(.N(4), .MAX_HOLD(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
`ifdef RR_ARB_HOLD_EN
        .hold        (hold),
`endif
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] g,
                       input logic [1:0] id, input logic v);
        checks++;
        assert ({grant, grant_id, grant_valid} === {g, id, v})
        else begin
            errors++;
            $error("FAIL %s: observed grant=%b id=%0d valid=%b, expected grant=%b id=%0d valid=%b",
                   tag, grant, grant_id, grant_valid, g, id, v);
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
`ifdef RR_ARB_HOLD_EN
        hold  = 1'b0;
`endif
        step();
        step();
        chk("reset_state", 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;

        // Idle with no requests
        step();
        chk("idle_no_req", 4'b0000, 2'd0, 1'b0);

        // Full rotation, ptr starts at 0
        req = 4'b1111;
        step(); chk("rot0", 4'b0001, 2'd0, 1'b1);
        step(); chk("rot1", 4'b0010, 2'd1, 1'b1);
        step(); chk("rot2", 4'b0100, 2'd2, 1'b1);
        step(); chk("rot3", 4'b1000, 2'd3, 1'b1);
        step(); chk("rot_wrap", 4'b0001, 2'd0, 1'b1);

        req = 4'b0000;
        step(); chk("rot_idle", 4'b0000, 2'd0, 1'b0);

        // Sparse: ptr=1, so index 3 wins first, then wrap to 0
        req = 4'b1001;
        step(); chk("sparse_a", 4'b1000, 2'd3, 1'b1);
        step(); chk("sparse_b", 4'b0001, 2'd0, 1'b1);
        step(); chk("sparse_c", 4'b1000, 2'd3, 1'b1);
        step(); chk("sparse_d", 4'b0001, 2'd0, 1'b1);

        // Handover with no gap: ptr=1 -> index 2, then 2 drops as 3 rises
        req = 4'b0100;
        step(); chk("handover_a", 4'b0100, 2'd2, 1'b1);
        req = 4'b1000;
        step(); chk("handover_b", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        step(); chk("handover_idle", 4'b0000, 2'd0, 1'b0);

        // Reset mid-grant: ptr=0 -> 1 then 2
        req = 4'b0110;
        step(); chk("pre_rst_a", 4'b0010, 2'd1, 1'b1);
        step(); chk("pre_rst_b", 4'b0100, 2'd2, 1'b1);
        #2 reset = 1'b0;
        #1 chk("async_reset", 4'b0000, 2'd0, 1'b0);
        step(); chk("in_reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;
        step(); chk("post_rst_a", 4'b0010, 2'd1, 1'b1);
        step(); chk("post_rst_b", 4'b0100, 2'd2, 1'b1);

        // Grantee 2 drops, index 1 still asking: ptr=3 wraps to index 1
        req = 4'b0010;
        step(); chk("drop_other", 4'b0010, 2'd1, 1'b1);

        // Sole requestor wins every cycle without hold
        req = 4'b0100;
        step(); chk("sole_a", 4'b0100, 2'd2, 1'b1);
        step(); chk("sole_b", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        step(); chk("sole_idle", 4'b0000, 2'd0, 1'b0);

`ifdef RR_ARB_HOLD_EN
        // Hold limit MAX_HOLD=3, ptr=3 -> index 0 first
        req  = 4'b0011;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk($sformatf("hold0_%0d", k), 4'b0001, 2'd0, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            step(); chk($sformatf("hold1_%0d", k), 4'b0010, 2'd1, 1'b1);
        end
        step(); chk("hold0_again", 4'b0001, 2'd0, 1'b1);

        // Sole holder keeps the grant indefinitely
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            step(); chk($sformatf("sole_hold_%0d", k), 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0000;
        step(); chk("sole_hold_drop", 4'b0000, 2'd0, 1'b0);
        hold = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin arbiter for N requestors with registered one-hot grant, encoded grant index, and optional grant hold (locked multi-cycle transfers) bounded by a starvation limit. Successor to the fixed 4-way masked-priority arbiter. Sits between N request sources and a single shared resource (bus port, memory channel). Fairness comes from a rotating priority pointer that moves past the last grantee.

## Interface
Parameters:
- N, 4, number of requestors; N ≥ 2.
- MAX_HOLD, 8, maximum consecutive cycles one grantee may keep a held grant while others are waiting; MAX_HOLD ≥ 1.

Ports (IW = $clog2(N)):
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high means requestor i wants the resource.
- hold  input  1  current grantee requests that its grant continue next cycle. Present only with RR_ARB_HOLD_EN.
- grant  output  N  registered one-hot grant, or all zeros.
- grant_id  output  IW  index of the granted requestor; meaningful only when grant_valid is high.
- grant_valid  output  1  high when grant is non-zero.

## Operation
- State machine with two states:
  - IDLE: no grant is active.
  - GRANT: exactly one grant bit is set.
- Pointer ptr (IW bits):
  - ptr marks the highest-priority index.
  - Priority falls off from ptr upward, wrapping modulo N: ptr, ptr+1, …, N-1, 0, …, ptr-1.
- Winner selection is masked-then-unmasked:
  - Masked search covers req bits with index ≥ ptr; the lowest set bit wins.
  - If no masked bit is set, the unmasked search runs over all of req; the lowest set bit wins.
- When a new grant is issued to index w, ptr takes (w+1) mod N on the same edge.
- IDLE behaviour:
  - If req ≠ 0, issue a grant to the winner and enter GRANT.
  - Otherwise stay in IDLE; grant stays 0.
- GRANT behaviour with current grantee c:
  - Keep the grant if all of these hold: hold = 1, req[c] = 1, and either hold_cnt < MAX_HOLD-1 or no other req bit is set. hold_cnt then increments, saturating at MAX_HOLD-1.
  - Otherwise re-arbitrate over req using the already-advanced ptr. If c is the only requestor, it wins again. hold_cnt clears.
  - If req = 0, enter IDLE and clear grant.
- A grant is issued only to a requestor whose req bit was high at the sampling edge. Dropping req while granted removes the grant on the next edge.
- hold has no effect in IDLE or when req[c] = 0.

## Timing
- Reset (reset low):
  - Takes effect immediately, asynchronously, at any time.
  - Drives grant = 0, grant_id = 0, grant_valid = 0, ptr = 0, hold_cnt = 0, state IDLE.
- After reset releases, the first active clock edge is the first sampling edge.
- Latency:
  - req sampled at edge k produces grant visible after edge k, one cycle of latency.
  - No combinational path from req to grant.
- Without hold, each grant lasts exactly one cycle. Continuous requestors rotate every cycle.
- With hold, a single grantee holds for at most MAX_HOLD consecutive cycles while any other req is set. It holds indefinitely if it is the only requestor.
- Simultaneous events:
  - The grantee drops req while another requestor raises req: the other requestor is granted on the same edge. No idle cycle is inserted.
  - Wrap-around: with ptr = 0 after grantee N-1, index 0 is top priority.
- Worst-case wait for a continuously requesting source: (N-1)·MAX_HOLD cycles with hold, N-1 cycles without.

## Configuration
- RR_ARB_HOLD_EN defined:
  - The hold port, hold_cnt register and MAX_HOLD limit are compiled in.
- RR_ARB_HOLD_EN undefined:
  - The hold port and hold_cnt are absent and MAX_HOLD is unused.
  - Every GRANT cycle re-arbitrates, so each grant is a single-cycle grant.

## Test plan
- Reset mid-grant: N=4, req=4'b0110 and a grant active. Assert reset low between edges → grant=0, grant_valid=0, grant_id=0 immediately. The first grant after release goes to index 1.
- Full rotation: req=4'b1111 held, no hold → grant sequence is 0001, 0010, 0100, 1000, 0001, one step per cycle. grant_id follows 0, 1, 2, 3, 0.
- Sparse wrap-around: req=4'b1001 held → grants alternate 0001, 1000, 0001. grant_id is never 1 or 2.
- Hold limit (RR_ARB_HOLD_EN, MAX_HOLD=3): req=4'b0011, hold=1 → index 0 granted for 3 cycles, then index 1 for 3 cycles, then index 0 again.
- Sole holder and drop: req=4'b0100, hold=1 for 20 cycles → grant=0100 throughout. Then req goes to 0 → grant=0 and grant_valid=0 after the next edge, state IDLE.
- Handover with no gap: grantee 2 drops req on the same edge index 3 raises req (req goes 0100→1000) → grant=1000 on the next cycle.
